ps_upsizer: RTL and testbench



---
 rtl/ps_pkg.sv | 12 +
 rtl/ps_upsizer.sv | 92 +++++++++
 tb/tb_ps_upsizer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_pkg.sv
// ps_pkg: shared PacketStream helpers.
//   ps_cnt_width(ratio) - width of a lane-count field able to hold ratio-1,
//                         never narrower than one bit.
package ps_pkg;

  function automatic int ps_cnt_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ps_upsizer.sv
// ps_upsizer: PacketStream width up-converter.
// Packs RATIO consecutive IWIDTH-bit input words into one IWIDTH*RATIO-bit
// output word (first word of a group in lane 0). An end-of-packet word
// flushes a partial group with the unused upper lanes zeroed, and o_cnt
// reports the number of valid lanes minus one.
//
// Handshake: a word moves on either side when val & rdy are both high at a
// rising clk edge. i_rdy depends only on the output register (~o_val | o_rdy),
// never on i_val/i_eop, so the input stalls only while a finished word waits.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   i_dat/i_val/i_eop/i_rdy   narrow input stream
//   o_dat/o_val/o_eop/o_cnt/o_rdy  wide output stream (all registered but i_rdy)
module ps_upsizer
  import ps_pkg::*;
#(
  parameter int IWIDTH = 8,
  parameter int RATIO  = 4,
  localparam int CWIDTH = ps_cnt_width(RATIO)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IWIDTH-1:0]        i_dat,
  input  logic                     i_val,
  input  logic                     i_eop,
  output logic                     i_rdy,
  output logic [IWIDTH*RATIO-1:0]  o_dat,
  output logic                     o_val,
  output logic                     o_eop,
  output logic [CWIDTH-1:0]        o_cnt,
  input  logic                     o_rdy
);

  localparam int OWIDTH = IWIDTH * RATIO;
  localparam logic [CWIDTH-1:0] LAST = CWIDTH'(RATIO - 1);

  logic [CWIDTH-1:0] idx;
  logic [OWIDTH-1:0] acc;
  logic [OWIDTH-1:0] acc_nxt;
  logic [OWIDTH-1:0] packed_dat;
  logic              accept;
  logic              complete;

  assign i_rdy    = ~o_val | o_rdy;
  assign accept   = i_val & i_rdy;
  assign complete = accept & ((idx == LAST) | i_eop);

  // Per-lane views: acc_nxt is the accumulator after a non-completing write,
  // packed_dat is the word handed to the output register on completion
  // (lanes below idx from acc, lane idx from the incoming word, rest zero).
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    localparam logic [CWIDTH-1:0] K = CWIDTH'(k);
    logic [IWIDTH-1:0] acc_lane;

    assign acc_lane = acc[k*IWIDTH +: IWIDTH];
    assign acc_nxt[k*IWIDTH +: IWIDTH] =
      complete ? '0 : ((idx == K) ? i_dat : acc_lane);
    assign packed_dat[k*IWIDTH +: IWIDTH] =
      (K < idx) ? acc_lane : ((K == idx) ? i_dat : '0);
  end

  // Accumulator and lane index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      idx <= complete ? '0 : idx + 1'b1;
    end
  end

  // Output register. A completing word reloads it even at the edge where the
  // previous word drains, so back-to-back outputs carry no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_dat <= '0;
      o_val <= 1'b0;
      o_eop <= 1'b0;
      o_cnt <= '0;
    end else if (complete) begin
      o_dat <= packed_dat;
      o_val <= 1'b1;
      o_eop <= i_eop;
      o_cnt <= idx;
    end else if (o_rdy) begin
      o_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps_upsizer.sv
// Testbench for ps_upsizer: three instances (RATIO 3, 4, 5, IWIDTH 8), each
// test exercises one of them. Expected output words come from a packet-level
// model: input words are collected into a list and a wide word is emitted
// when the list reaches RATIO entries or the packet ends.
module tb_ps_upsizer;

  typedef logic [47:0] ent_t;  // {3'b0, eop, cnt[3:0], dat[39:0]}

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // RATIO = 3
  logic [7:0]  i_dat_3;
  logic        i_val_3, i_eop_3, i_rdy_3;
  logic [23:0] o_dat_3;
  logic        o_val_3, o_eop_3, o_rdy_3;
  logic [1:0]  o_cnt_3;
  // RATIO = 4
  logic [7:0]  i_dat_4;
  logic        i_val_4, i_eop_4, i_rdy_4;
  logic [31:0] o_dat_4;
  logic        o_val_4, o_eop_4, o_rdy_4;
  logic [1:0]  o_cnt_4;
  // RATIO = 5
  logic [7:0]  i_dat_5;
  logic        i_val_5, i_eop_5, i_rdy_5;
  logic [39:0] o_dat_5;
  logic        o_val_5, o_eop_5, o_rdy_5;
  logic [2:0]  o_cnt_5;

  ps_upsizer #(.IWIDTH(8), .RATIO(3)) u_r3 (
    .clk(clk), .reset(reset), .i_dat(i_dat_3), .i_val(i_val_3), .i_eop(i_eop_3),
    .i_rdy(i_rdy_3), .o_dat(o_dat_3), .o_val(o_val_3), .o_eop(o_eop_3),
    .o_cnt(o_cnt_3), .o_rdy(o_rdy_3));
  ps_upsizer #(.IWIDTH(8), .RATIO(4)) u_r4 (
    .clk(clk), .reset(reset), .i_dat(i_dat_4), .i_val(i_val_4), .i_eop(i_eop_4),
    .i_rdy(i_rdy_4), .o_dat(o_dat_4), .o_val(o_val_4), .o_eop(o_eop_4),
    .o_cnt(o_cnt_4), .o_rdy(o_rdy_4));
  ps_upsizer #(.IWIDTH(8), .RATIO(5)) u_r5 (
    .clk(clk), .reset(reset), .i_dat(i_dat_5), .i_val(i_val_5), .i_eop(i_eop_5),
    .i_rdy(i_rdy_5), .o_dat(o_dat_5), .o_val(o_val_5), .o_eop(o_eop_5),
    .o_cnt(o_cnt_5), .o_rdy(o_rdy_5));

  // scoreboard
  ent_t       exp_q[$];
  ent_t       obs_q[$];
  logic [7:0] pend[$];
  int         checks = 0;
  int         errors = 0;
  int         stall_cycles = 0;

  function automatic ent_t enc(input logic [39:0] dat, input logic [3:0] cnt,
                               input logic eop);
    return {3'b000, eop, cnt, dat};
  endfunction

  // Reference model: group words, flush on full group or end of packet.
  task automatic model_word(input int ratio, input logic [7:0] w, input logic eop);
    logic [39:0] dat;
    pend.push_back(w);
    if (pend.size() == ratio || eop) begin
      dat = '0;
      for (int k = 0; k < pend.size(); k++) dat = dat | (40'(pend[k]) << (8 * k));
      exp_q.push_back(enc(dat, 4'(pend.size() - 1), eop));
      pend.delete();
    end
  endtask

  // Output monitor: a transfer happens at the next rising edge when val&rdy.
  always @(negedge clk) begin
    if (reset) begin
      if (o_val_3 && o_rdy_3) obs_q.push_back(enc(40'(o_dat_3), 4'(o_cnt_3), o_eop_3));
      if (o_val_4 && o_rdy_4) obs_q.push_back(enc(40'(o_dat_4), 4'(o_cnt_4), o_eop_4));
      if (o_val_5 && o_rdy_5) obs_q.push_back(enc(40'(o_dat_5), 4'(o_cnt_5), o_eop_5));
    end
  end

  // driver tasks
  task automatic set_in(input int sel, input logic [7:0] d, input logic v, input logic e);
    case (sel)
      3: begin i_dat_3 = d; i_val_3 = v; i_eop_3 = e; end
      4: begin i_dat_4 = d; i_val_4 = v; i_eop_4 = e; end
      5: begin i_dat_5 = d; i_val_5 = v; i_eop_5 = e; end
      default: ;
    endcase
  endtask

  function automatic logic get_rdy(input int sel);
    case (sel)
      3: return i_rdy_3;
      4: return i_rdy_4;
      default: return i_rdy_5;
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send_word(input int sel, input logic [7:0] w, input logic eop,
                           input int gap);
    bit ok;
    ok = 0;
    if (gap > 0) begin
      set_in(sel, 8'h00, 1'b0, 1'b0);
      repeat (gap) begin @(posedge clk); #1; end
    end
    set_in(sel, w, 1'b1, eop);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (get_rdy(sel)) begin ok = 1; break; end
      stall_cycles++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_in(sel, w, 1'b0, 1'b0);
    if (!ok) begin
      errors++;
      $display("FAIL send_word_timeout: ratio %0d word %h never accepted, want accept", sel, w);
    end else begin
      model_word(sel, w, eop);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    pend.delete();
    stall_cycles = 0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    // Inputs active during reset must be ignored; i_rdy still reads 1.
    i_val_4 = 1'b1; i_dat_4 = 8'hFF; i_eop_4 = 1'b1; o_rdy_4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_val_4 !== 1'b0) begin errors++; $display("FAIL reset_o_val: got %b want 0", o_val_4); end
    checks++; if (o_eop_4 !== 1'b0) begin errors++; $display("FAIL reset_o_eop: got %b want 0", o_eop_4); end
    checks++; if (o_cnt_4 !== 2'd0) begin errors++; $display("FAIL reset_o_cnt: got %0d want 0", o_cnt_4); end
    checks++; if (o_dat_4 !== 32'h0) begin errors++; $display("FAIL reset_o_dat: got %h want 0", o_dat_4); end
    checks++; if (i_rdy_4 !== 1'b1) begin errors++; $display("FAIL reset_i_rdy: got %b want 1", i_rdy_4); end
    checks++; if (o_val_3 !== 1'b0 || o_val_5 !== 1'b0) begin
      errors++; $display("FAIL reset_o_val_other: got %b%b want 00", o_val_3, o_val_5);
    end
    @(posedge clk); #1;
    i_val_4 = 1'b0; i_eop_4 = 1'b0; o_rdy_4 = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_sb();
    for (int i = 1; i <= 8; i++) begin
      send_word(4, 8'(i), i == 8, 0);
      if (i == 4) begin
        checks++; if (o_val_4 !== 1'b1) begin errors++; $display("FAIL basic_latency_val: got %b want 1", o_val_4); end
        checks++; if (o_dat_4 !== 32'h04030201) begin errors++; $display("FAIL basic_latency_dat: got %h want 04030201", o_dat_4); end
      end
    end
    idle(5);
    checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL basic_i_rdy_drop: got %0d stalls want 0", stall_cycles); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[1] !== enc(40'h08070605, 4'd3, 1'b1)) begin
        errors++; $display("FAIL basic_second_word: got %h want %h", obs_q[1], enc(40'h08070605, 4'd3, 1'b1));
      end
    end
  endtask

  task automatic test_tail();
    clear_sb();
    for (int i = 0; i < 6; i++) send_word(4, 8'h11 + 8'(i), i == 5, 0);
    idle(5);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tail_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tail_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[1] !== enc(40'h1615, 4'd1, 1'b1)) begin
        errors++; $display("FAIL tail_partial: got %h want %h", obs_q[1], enc(40'h1615, 4'd1, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    send_word(3, 8'hAA, 1'b1, 0);
    send_word(3, 8'hB1, 1'b0, 0);
    send_word(3, 8'hB2, 1'b0, 0);
    send_word(3, 8'hB3, 1'b1, 0);
    idle(5);
    checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL b2b_stall: got %0d stalls want 0", stall_cycles); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 2) begin
      checks++; if (obs_q[0] !== enc(40'hAA, 4'd0, 1'b1) || obs_q[1] !== enc(40'hB3B2B1, 4'd2, 1'b1)) begin
        errors++; $display("FAIL b2b_values: got %h %h want %h %h", obs_q[0], obs_q[1],
                           enc(40'hAA, 4'd0, 1'b1), enc(40'hB3B2B1, 4'd2, 1'b1));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_dat;
    logic [1:0]  held_cnt;
    logic        held_eop;
    bit          seen;
    clear_sb();
    seen = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_word(4, 8'($urandom_range(0, 255)), i == 11, 0);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(posedge clk); #1;
          if (o_val_4) begin seen = 1; break; end
        end
        o_rdy_4 = 1'b0;
        held_dat = o_dat_4; held_cnt = o_cnt_4; held_eop = o_eop_4;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++; if (o_dat_4 !== held_dat || o_cnt_4 !== held_cnt || o_eop_4 !== held_eop) begin
            errors++; $display("FAIL stall_hold c%0d: got %h/%0d/%b want %h/%0d/%b", c,
                               o_dat_4, o_cnt_4, o_eop_4, held_dat, held_cnt, held_eop);
          end
          checks++; if (i_rdy_4 !== 1'b0) begin errors++; $display("FAIL stall_i_rdy c%0d: got %b want 0", c, i_rdy_4); end
          @(posedge clk); #1;
        end
        o_rdy_4 = 1'b1;
      end
    join
    idle(6);
    checks++; if (!seen) begin errors++; $display("FAIL stall_no_output: got none want o_val"); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send_word(4, 8'h31, 1'b0, 0);
    send_word(4, 8'h32, 1'b0, 0);
    reset = 1'b0;
    pend.delete();  // partial group is discarded by reset
    @(negedge clk);
    checks++; if (o_val_4 !== 1'b0 || o_eop_4 !== 1'b0 || o_cnt_4 !== 2'd0) begin
      errors++; $display("FAIL rstmid_ctrl: got val%b eop%b cnt%0d want 0/0/0", o_val_4, o_eop_4, o_cnt_4);
    end
    checks++; if (o_dat_4 !== 32'h0) begin errors++; $display("FAIL rstmid_dat: got %h want 0", o_dat_4); end
    checks++; if (i_rdy_4 !== 1'b1) begin errors++; $display("FAIL rstmid_i_rdy: got %b want 1", i_rdy_4); end
    @(posedge clk); #1;
    idle(1);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send_word(4, 8'h21 + 8'(i), i == 3, 0);
    idle(5);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== enc(40'h24232221, 4'd3, 1'b1)) begin
        errors++; $display("FAIL rstmid_value: got %h want %h", obs_q[0], enc(40'h24232221, 4'd3, 1'b1));
      end
    end
  endtask

  task automatic test_random();
    bit done;
    int len;
    clear_sb();
    done = 0;
    fork
      begin
        for (int p = 0; p < 15; p++) begin
          len = $urandom_range(1, 20);
          for (int i = 0; i < len; i++)
            send_word(5, 8'($urandom_range(0, 255)), i == len - 1, $urandom_range(0, 2));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          o_rdy_5 = ($urandom_range(0, 3) != 0);
        end
        o_rdy_5 = 1'b1;
      end
    join
    for (int t = 0; t < 200 && obs_q.size() < exp_q.size(); t++) idle(1);
    idle(3);
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_dat_3 = '0; i_val_3 = 1'b0; i_eop_3 = 1'b0; o_rdy_3 = 1'b1;
    i_dat_4 = '0; i_val_4 = 1'b0; i_eop_4 = 1'b0; o_rdy_4 = 1'b1;
    i_dat_5 = '0; i_val_5 = 1'b0; i_eop_5 = 1'b0; o_rdy_5 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_tail();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
